// File: rtl/npu_conv_pkg.sv
// Shared definitions for the convolution window feeder: FSM encoding,
// default pixel width and the counter-width helper.
package npu_conv_pkg;

    localparam int BIT_DEPTH_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_scan_counter.sv
// Row/column scan counters plus the running row-base address (r*IMG_W),
// advanced once per issued SRAM read.
module window_scan_counter
    import npu_conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       advance_i,
    output logic [cnt_w(IMG_H)-1:0]    r_o,
    output logic [cnt_w(IMG_W)-1:0]    c_o,
    output logic [ADDR_W-1:0]          base_o,
    output logic                       last_o
);

    localparam int RW = cnt_w(IMG_H);
    localparam int CW = cnt_w(IMG_W);
    localparam logic [RW-1:0]     R_LAST = RW'(IMG_H - 3);
    localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(IMG_W);

    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              col_end;

    assign col_end = (c_q == C_LAST);

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        base_d = base_q;
        if (clear_i) begin
            r_d    = '0;
            c_d    = '0;
            base_d = '0;
        end else if (advance_i) begin
            if (col_end) begin
                c_d    = '0;
                r_d    = r_q + RW'(1);
                base_d = base_q + W_STEP;
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            c_q    <= '0;
            base_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            base_q <= base_d;
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign base_o = base_q;
    assign last_o = (r_q == R_LAST) && col_end;

endmodule

// File: rtl/conv_window_feeder.sv
// Scans an IMG_H x IMG_W frame three rows at a time, feeding the 3x3 line
// buffer and flagging every cycle in which it holds a complete window.
module conv_window_feeder
    import npu_conv_pkg::*;
#(
    parameter int BIT_DEPTH = BIT_DEPTH_DFLT,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr_r1,
    output logic [ADDR_W-1:0]         rd_addr_r2,
    output logic [ADDR_W-1:0]         rd_addr_r3,
    input  logic [BIT_DEPTH-1:0]      rd_data_r1,
    input  logic [BIT_DEPTH-1:0]      rd_data_r2,
    input  logic [BIT_DEPTH-1:0]      rd_data_r3,
    output logic [BIT_DEPTH-1:0]      data_out_r1,
    output logic [BIT_DEPTH-1:0]      data_out_r2,
    output logic [BIT_DEPTH-1:0]      data_out_r3,
    output logic                      wr_en,
    output logic                      shift,
    output logic                      win_valid,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] W_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W_STEP2 = ADDR_W'(2 * IMG_W);

    fsm_state_e        state_q, state_d;
    logic [RW-1:0]     scan_r;
    logic [CW-1:0]     scan_c;
    logic [ADDR_W-1:0] scan_base;
    logic [ADDR_W-1:0] col_off;
    logic              scan_last;
    logic              scan_adv;
    logic              scan_clear;

    logic              wr_q;
    logic              last_wr_q;
    logic              last_win_q;
    logic              win_valid_q;
    logic [RW-1:0]     wr_row_q, win_row_q;
    logic [CW-1:0]     wr_col_q, win_col_q;

    assign scan_adv   = (state_q == ST_SCAN) && !stall;
    assign scan_clear = (state_q == ST_IDLE) && start;

    window_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (scan_clear),
        .advance_i (scan_adv),
        .r_o       (scan_r),
        .c_o       (scan_c),
        .base_o    (scan_base),
        .last_o    (scan_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                  state_d = ST_SCAN;
            ST_SCAN:  if (scan_adv && scan_last)  state_d = ST_DRAIN;
            // The final window is tagged so earlier windows still in flight
            // cannot end the drain early.
            ST_DRAIN: if (last_win_q)             state_d = ST_DONE;
            ST_DONE:                              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            last_wr_q   <= 1'b0;
            last_win_q  <= 1'b0;
            win_valid_q <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= scan_adv;
            last_wr_q   <= scan_adv && scan_last;
            last_win_q  <= last_wr_q;
            win_valid_q <= wr_q && (wr_col_q >= CW'(2));
            if (scan_adv) begin
                wr_row_q <= scan_r;
                wr_col_q <= scan_c;
            end
            // Columns 0 and 1 of a band only prime the buffer.
            if (wr_q && (wr_col_q >= CW'(2))) begin
                win_row_q <= wr_row_q;
                win_col_q <= wr_col_q - CW'(2);
            end
        end
    end

    assign col_off    = ADDR_W'(scan_c);
    assign rd_en      = scan_adv;
    assign rd_addr_r1 = rd_en ? (scan_base + col_off)           : '0;
    assign rd_addr_r2 = rd_en ? (scan_base + W_STEP + col_off)  : '0;
    assign rd_addr_r3 = rd_en ? (scan_base + W_STEP2 + col_off) : '0;

    assign data_out_r1 = rd_data_r1;
    assign data_out_r2 = rd_data_r2;
    assign data_out_r3 = rd_data_r3;

    assign wr_en     = wr_q;
    assign shift     = wr_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a 5x4 frame instance checked
// against a frame-level model, plus a minimal 3x3 instance.
module tb_conv_window_feeder;

    localparam int BD  = 8;
    localparam int W   = 5;
    localparam int H   = 4;
    localparam int AW  = 16;
    localparam int RW  = $clog2(H);
    localparam int CW  = $clog2(W);
    localparam int SW  = 3;
    localparam int SH  = 3;
    localparam int SRW = $clog2(SH);
    localparam int SCW = $clog2(SW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Main instance
    logic          start = 1'b0, stall = 1'b0;
    logic          busy, done, rd_en, wr_en, shift, win_valid;
    logic [AW-1:0] a1, a2, a3;
    logic [BD-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [BD-1:0] o1, o2, o3;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    conv_window_feeder #(.BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_r1(a1), .rd_addr_r2(a2), .rd_addr_r3(a3),
        .rd_data_r1(d1), .rd_data_r2(d2), .rd_data_r3(d3),
        .data_out_r1(o1), .data_out_r2(o2), .data_out_r3(o3),
        .wr_en(wr_en), .shift(shift), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col)
    );

    // SRAM model: pixel value equals its address, one-cycle latency
    always @(posedge clk) begin
        if (rd_en) begin
            d1 <= a1[BD-1:0];
            d2 <= a2[BD-1:0];
            d3 <= a3[BD-1:0];
        end
    end

    // Small 3x3 instance
    logic           s_start = 1'b0, s_stall = 1'b0;
    logic           s_busy, s_done, s_rd_en, s_wr_en, s_shift, s_win_valid;
    logic [AW-1:0]  s_a1, s_a2, s_a3;
    logic [BD-1:0]  s_d1 = '0, s_d2 = '0, s_d3 = '0;
    logic [BD-1:0]  s_o1, s_o2, s_o3;
    logic [SRW-1:0] s_win_row;
    logic [SCW-1:0] s_win_col;

    conv_window_feeder #(.BIT_DEPTH(BD), .IMG_W(SW), .IMG_H(SH), .ADDR_W(AW)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_stall),
        .busy(s_busy), .done(s_done), .rd_en(s_rd_en),
        .rd_addr_r1(s_a1), .rd_addr_r2(s_a2), .rd_addr_r3(s_a3),
        .rd_data_r1(s_d1), .rd_data_r2(s_d2), .rd_data_r3(s_d3),
        .data_out_r1(s_o1), .data_out_r2(s_o2), .data_out_r3(s_o3),
        .wr_en(s_wr_en), .shift(s_shift), .win_valid(s_win_valid),
        .win_row(s_win_row), .win_col(s_win_col)
    );

    always @(posedge clk) begin
        if (s_rd_en) begin
            s_d1 <= s_a1[BD-1:0];
            s_d2 <= s_a2[BD-1:0];
            s_d3 <= s_a3[BD-1:0];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference model
    typedef struct { int a1; int a2; int a3; } rd_t;
    typedef struct { int r; int c; } win_t;
    rd_t  exp_rd[$];
    rd_t  pend_wr[$];
    win_t exp_win[$];
    int   lb[3][3];
    int   last_win_cyc = -100;
    bit   mon_en = 1'b1;

    task automatic push_frame();
        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c < W; c++) begin
                rd_t e;
                e.a1 = r * W + c;
                e.a2 = (r + 1) * W + c;
                e.a3 = (r + 2) * W + c;
                exp_rd.push_back(e);
                if (c <= W - 3) begin
                    win_t w;
                    w.r = r;
                    w.c = c;
                    exp_win.push_back(w);
                end
            end
        end
    endtask

    // Monitor: window checked before this cycle's write shifts the model
    always @(negedge clk) begin
        rd_t  e;
        win_t w;
        if (rst_n && mon_en) begin
            if (win_valid) begin
                if (exp_win.size() == 0) chk("unexpected_win_valid", 1, 0);
                else begin
                    w = exp_win.pop_front();
                    chk("win_row", win_row, w.r);
                    chk("win_col", win_col, w.c);
                    for (int k = 0; k < 3; k++)
                        for (int j = 0; j < 3; j++)
                            chk("lb_window_pixel", lb[k][j], (w.r + k) * W + w.c + j);
                    last_win_cyc = cyc;
                end
            end
            if (rd_en) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_en", 1, 0);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_addr_r1", a1, e.a1);
                    chk("rd_addr_r2", a2, e.a2);
                    chk("rd_addr_r3", a3, e.a3);
                    pend_wr.push_back(e);
                end
            end
            if (wr_en || shift) chk("shift_eq_wr_en", shift, wr_en);
            if (wr_en) begin
                if (pend_wr.size() == 0) chk("unexpected_wr_en", 1, 0);
                else begin
                    e = pend_wr.pop_front();
                    chk("data_out_r1", o1, e.a1 % 256);
                    chk("data_out_r2", o2, e.a2 % 256);
                    chk("data_out_r3", o3, e.a3 % 256);
                    for (int k = 0; k < 3; k++) begin
                        lb[k][0] = lb[k][1];
                        lb[k][1] = lb[k][2];
                    end
                    lb[0][2] = int'(o1);
                    lb[1][2] = int'(o2);
                    lb[2][2] = int'(o3);
                end
            end
            if (done) begin
                chk("done_after_last_win", cyc - last_win_cyc, 1);
                chk("windows_left_at_done", exp_win.size(), 0);
                chk("reads_left_at_done", exp_rd.size(), 0);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // mode 0: no stall, 1: stall cycles 3..5, 2: random stall
    task automatic run_frame(input int mode, input int exp_len, input bit glitch);
        bit got = 1'b0;
        int len = 0;
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            case (mode)
                0:       stall = 1'b0;
                1:       stall = (k >= 3 && k <= 5);
                default: stall = ($urandom_range(0, 3) == 0);
            endcase
            start = glitch && (k == 4);
            @(negedge clk);
            if (k == 1) chk("busy_after_start", busy, 1);
            if (done) begin
                got = 1'b1;
                len = k;
                break;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        else if (exp_len > 0) chk("frame_len", len, exp_len);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("wr_pending_after_frame", pend_wr.size(), 0);
        $display("frame mode=%0d glitch=%0d len=%0d total=%0d", mode, glitch, len, total);
    endtask

    task automatic reset_abort();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        mon_en = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_shift", shift, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_addr_r1", a1, 0);
        chk("rst_addr_r2", a2, 0);
        chk("rst_addr_r3", a3, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        exp_rd.delete();
        pend_wr.delete();
        exp_win.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_wr_en", wr_en, 0);
            chk("post_rst_rd_en", rd_en, 0);
            chk("post_rst_win_valid", win_valid, 0);
        end
        $display("reset abort total=%0d", total);
    endtask

    task automatic small_frame();
        int nrd = 0, nwin = 0, ndone = 0, win_k = -1, done_k = -1;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_rd_en) begin
                chk("small_rd_addr_r1", s_a1, nrd);
                chk("small_rd_addr_r2", s_a2, nrd + SW);
                chk("small_rd_addr_r3", s_a3, nrd + 2 * SW);
                nrd++;
            end
            if (s_win_valid) begin
                chk("small_win_row", s_win_row, 0);
                chk("small_win_col", s_win_col, 0);
                nwin++;
                win_k = k;
            end
            if (s_done) begin
                ndone++;
                done_k = k;
            end
            @(posedge clk); #1;
        end
        chk("small_reads", nrd, 3);
        chk("small_windows", nwin, 1);
        chk("small_done_count", ndone, 1);
        chk("small_done_after_win", done_k - win_k, 1);
        $display("small frame reads=%0d windows=%0d", nrd, nwin);
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                lb[k][j] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_addr_r1", a1, 0);

        run_frame(0, 13, 1'b0);
        run_frame(1, 16, 1'b0);
        run_frame(0, 13, 1'b1);
        reset_abort();
        run_frame(0, 13, 1'b0);
        for (int i = 0; i < 3; i++) run_frame(2, 0, 1'b0);
        small_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream stage of the 3x3 convolution line buffer.
- Scans an IMG_H x IMG_W image held in a 3-read-port feature SRAM.
- For each column, fetches three vertically adjacent pixels (rows r, r+1, r+2) and drives them into the line buffer with write/shift strobes.
- Flags each cycle in which the line buffer holds a complete 3x3 window, tagged with its top-left coordinate.

Parameters:
- BIT_DEPTH, 8, pixel width.
- IMG_W, 8, image width in pixels; must be >= 3.
- IMG_H, 8, image height in pixels; must be >= 3.
- ADDR_W, 16, SRAM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame scan; sampled only in IDLE.
- stall  in  1  when high, no new SRAM read is issued this cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of frame.
- rd_en  out  1  SRAM read strobe, shared by all three ports.
- rd_addr_r1/r2/r3  out  ADDR_W each  addresses for rows r, r+1, r+2 of column c.
- rd_data_r1/r2/r3  in  BIT_DEPTH each  SRAM read data; valid exactly 1 cycle after rd_en.
- data_out_r1/r2/r3  out  BIT_DEPTH each  pixel to line buffer rows 1..3; combinational pass-through of rd_data_rN.
- wr_en  out  1  line-buffer write strobe.
- shift  out  1  line-buffer shift strobe; always equal to wr_en.
- win_valid  out  1  line buffer holds a full window this cycle.
- win_row  out  $clog2(IMG_H)  top-left row of the current window.
- win_col  out  $clog2(IMG_W)  top-left column of the current window.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low, on rst_n; the single clock is clk.
  - Reset clears to IDLE; busy, done, rd_en, wr_en, shift, win_valid, all addresses, win_row, win_col and all counters go to 0.
  - Reset mid-frame aborts the scan immediately and discards in-flight reads (no wr_en follows).
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 at a clock edge moves to SCAN with r=0, c=0.
  - start while not in IDLE is ignored.
- SCAN, each cycle with stall=0:
  - rd_en=1.
  - rd_addr_r1 = r*IMG_W+c, rd_addr_r2 = (r+1)*IMG_W+c, rd_addr_r3 = (r+2)*IMG_W+c.
  - c increments.
  - At c=IMG_W-1: c wraps to 0 and r increments.
  - At r=IMG_H-3 and c=IMG_W-1: the final read issues and the FSM moves to DRAIN.
- SCAN with stall=1: rd_en=0, r and c hold.
- Write path:
  - wr_en and shift are rd_en registered by one cycle.
  - This read is always completed even if stall rises in that cycle.
- Window flag:
  - win_valid is registered: high in the cycle after a wr_en for column c >= 2 of the band.
  - win_row = r and win_col = c-2 of that write.
  - The first two columns of every band only prime the buffer: no win_valid.
  - Band change (r -> r+1) re-primes; no window ever spans two bands.
- Windows per frame: exactly (IMG_W-2)*(IMG_H-2).
- Downstream must consume the window in its win_valid cycle; the next write may change it. There is no backpressure beyond stall.
- DRAIN: waits until the final win_valid cycle has occurred, then moves to DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, FSM returns to IDLE.
- Address arithmetic is unsigned. The row-base is kept as a running sum (add IMG_W per band); no multiplier.

Decomposition:
- Shared package npu_conv_pkg: FSM state enum, BIT_DEPTH default, helper function for counter widths.
- One natural sub-module, window_scan_counter:
  - Holds the r/c counters and row-base accumulator.
  - Inputs: advance, clear.
  - Outputs: r, c, base, last.
- FSM and strobe pipeline stay in the top module.

Test Plan:
- IMG_W=5, IMG_H=4, no stall, start pulse -> 10 rd_en cycles; first addresses (0,5,10), last (9,14,19); 6 win_valid pulses with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); done exactly 1 cycle after the last win_valid.
- Same config, stall held high for 3 cycles after the 2nd read -> rd_en gap of 3 cycles, addresses resume at column 2, the pending 2nd read still produces wr_en, the 6 windows are unchanged, done is delayed 3 cycles.
- SRAM model returning pixel = address -> at window (1,2): data_out_r1/r2/r3 on its final write = 9,14,19; the line-buffer model holds columns 2..4 of rows 1..3.
- rst_n asserted 4 cycles into SCAN -> all outputs 0 asynchronously; no wr_en after release; a new start rescans from address 0.
- start pulsed while busy -> ignored; frame output is identical to the no-glitch run.
- IMG_W=3, IMG_H=3 -> 3 reads, exactly 1 win_valid at (0,0), then done.
